// File: rtl/alu_multicycle_if.sv
// Handshake and result bus of the multi-cycle ALU.
// The master (EX-stage control) presents operations; the slave is the ALU.
interface alu_multicycle_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               InValid;
    logic               InReady;
    logic [3:0]         ALUOperation;
    logic [SHAMT_W-1:0] Shamt;
    logic [WIDTH-1:0]   DataA;
    logic [WIDTH-1:0]   DataB;
    logic               OutValid;
    logic [WIDTH-1:0]   DataOut;
    logic               Zero;
    logic               Overflow;
    logic               Busy;

    modport master (
        output InValid, ALUOperation, Shamt, DataA, DataB,
        input  InReady, OutValid, DataOut, Zero, Overflow, Busy
    );

    modport slave (
        input  InValid, ALUOperation, Shamt, DataA, DataB,
        output InReady, OutValid, DataOut, Zero, Overflow, Busy
    );
endinterface

// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU with signed flags, shifts and a shift-add
// unsigned multiplier that writes HI/LO over WIDTH cycles.
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    alu_multicycle_if.slave   bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;

    localparam int MSB = WIDTH - 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t               state_q;
    logic [SHAMT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     data_q;
    logic                 zero_q;
    logic                 ovf_q;

    logic [WIDTH-1:0]     sum_d;
    logic [WIDTH-1:0]     diff_d;
    logic                 add_ovf_d;
    logic                 sub_ovf_d;
    logic                 slt_d;
    logic [WIDTH-1:0]     sra_d;
    logic [WIDTH-1:0]     res_d;
    logic                 ovf_d;
    logic [WIDTH:0]       mul_sum_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic                 accept;
    logic                 mul_last;

    assign accept   = bus.InValid && (state_q == IDLE);
    assign mul_last = (cnt_q == SHAMT_W'(WIDTH - 1));

    // Single-cycle result and flags for the operation presented this cycle.
    always_comb begin
        sum_d     = bus.DataA + bus.DataB;
        diff_d    = bus.DataA - bus.DataB;
        add_ovf_d = (bus.DataA[MSB] == bus.DataB[MSB]) && (sum_d[MSB] != bus.DataA[MSB]);
        sub_ovf_d = (bus.DataA[MSB] != bus.DataB[MSB]) && (diff_d[MSB] != bus.DataA[MSB]);
        // The sign of A-B is wrong exactly when the subtraction overflowed.
        slt_d     = diff_d[MSB] ^ sub_ovf_d;
        sra_d     = $unsigned($signed(bus.DataA) >>> bus.Shamt);
        res_d     = '0;
        ovf_d     = 1'b0;
        case (bus.ALUOperation)
            OP_AND:  res_d = bus.DataA & bus.DataB;
            OP_OR:   res_d = bus.DataA | bus.DataB;
            OP_ADD:  begin
                res_d = sum_d;
                ovf_d = add_ovf_d;
            end
            OP_SUB:  begin
                res_d = diff_d;
                ovf_d = sub_ovf_d;
            end
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, slt_d};
            OP_SRL:  res_d = bus.DataA >> bus.Shamt;
            OP_SLL:  res_d = bus.DataA << bus.Shamt;
            OP_SRA:  res_d = sra_d;
            OP_MFHI: res_d = hi_q;
            OP_MFLO: res_d = lo_q;
            default: res_d = '0;
        endcase
    end

    // One shift-add step: the multiplier sits in the low half of prod_q and
    // drains out to the right while the partial sum grows in the high half.
    always_comb begin
        mul_sum_d = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d    = {mul_sum_d, prod_q[WIDTH-1:1]};
    end

    // Control FSM, multiplier state, HI/LO and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (bus.ALUOperation == OP_MULT) begin
                            state_q <= MUL;
                            cnt_q   <= '0;
                            mcand_q <= bus.DataA;
                            prod_q  <= {{WIDTH{1'b0}}, bus.DataB};
                        end else begin
                            out_valid_q <= 1'b1;
                            data_q      <= res_d;
                            zero_q      <= (res_d == '0);
                            ovf_q       <= ovf_d;
                        end
                    end
                end
                MUL: begin
                    prod_q <= prod_d;
                    if (mul_last) begin
                        hi_q        <= prod_d[2*WIDTH-1:WIDTH];
                        lo_q        <= prod_d[WIDTH-1:0];
                        data_q      <= prod_d[WIDTH-1:0];
                        zero_q      <= (prod_d[WIDTH-1:0] == '0);
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + SHAMT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.InReady  = (state_q == IDLE);
    assign bus.Busy     = (state_q == MUL);
    assign bus.OutValid = out_valid_q;
    assign bus.DataOut  = data_q;
    assign bus.Zero     = zero_q;
    assign bus.Overflow = ovf_q;
endmodule
